// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the core sequencer. The top level and the debug
// LED mapping decode mode/stage with these same values.
package core_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_STALL = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_EXEC  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_WRITEREG = 3'd3,
    ST_STOP     = 3'd4
  } stage_t;

  // UART byte that moves the core from STALL into program load.
  localparam logic [7:0] BOOT_BYTE = 8'hAA;

  // Largest stage latency the 4-bit counter can hold with room to spare.
  localparam int unsigned LAT_MAX = 14;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: boot mode machine (STALL -> LOAD -> EXEC)
// and per-instruction stage machine with one-cycle latch-enable strobes.
module core_sequencer #(
  parameter int unsigned FETCH_LAT  = 0,
  parameter int unsigned DECODE_LAT = 0,
  parameter int unsigned EXEC_LAT   = 5,
  parameter logic [7:0]  BOOT_BYTE  = core_sequencer_pkg::BOOT_BYTE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        load_done,
  input  logic        exec_valid,
  input  logic        stop_req,
  input  logic        hold,
  output logic [1:0]  mode,
  output logic [2:0]  stage,
  output logic [3:0]  latency,
  output logic        fd_we,
  output logic        de_we,
  output logic        ew_we,
  output logic        wb_we,
  output logic        wb_clr,
  output logic        halted,
  output logic [31:0] retired
);

  import core_sequencer_pkg::*;

  // The counter is only 4 bits wide; reject parameter sets it cannot count to.
  if (FETCH_LAT > LAT_MAX || DECODE_LAT > LAT_MAX || EXEC_LAT > LAT_MAX) begin : g_lat_check
    $error("core_sequencer: FETCH_LAT, DECODE_LAT and EXEC_LAT must each be <= 14");
  end

  localparam logic [3:0] FETCH_LAT_L  = 4'(FETCH_LAT);
  localparam logic [3:0] DECODE_LAT_L = 4'(DECODE_LAT);
  localparam logic [3:0] EXEC_LAT_L   = 4'(EXEC_LAT);

  mode_t       mode_q;
  stage_t      stage_q;
  logic [3:0]  latency_q;
  logic [31:0] retired_q;

  // Strobe decode from the registered stage/count plus the live handshakes.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fd_we  = 1'b0;
    de_we  = 1'b0;
    ew_we  = 1'b0;
    wb_we  = 1'b0;
    wb_clr = 1'b0;
    if (mode_q == MODE_EXEC) begin
      case (stage_q)
        ST_FETCH:    fd_we  = !hold && (latency_q == FETCH_LAT_L);
        ST_DECODE:   de_we  = (latency_q == DECODE_LAT_L);
        ST_EXECUTE:  ew_we  = exec_valid && (latency_q == EXEC_LAT_L);
        ST_WRITEREG: begin
          wb_we  = (latency_q == 4'd0);
          wb_clr = (latency_q != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // Mode machine, stage machine, stage counter and retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= MODE_STALL;
      stage_q   <= ST_FETCH;
      latency_q <= 4'd0;
      retired_q <= 32'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // below sees the pre-edge values of all registers.
      case (mode_q)
        MODE_STALL: if (rx_ready && rx_data == BOOT_BYTE) mode_q <= MODE_LOAD;
        MODE_LOAD:  if (load_done) mode_q <= MODE_EXEC;
        default: ;
      endcase

      if (mode_q == MODE_EXEC) begin
        case (stage_q)
          ST_FETCH: begin
            if (hold) begin
              latency_q <= 4'd0;
            end else if (fd_we) begin
              latency_q <= 4'd0;
              stage_q   <= ST_DECODE;
            end else begin
              latency_q <= latency_q + 4'd1;
            end
          end
          ST_DECODE: begin
            if (de_we) begin
              latency_q <= 4'd0;
              stage_q   <= ST_EXECUTE;
            end else begin
              latency_q <= latency_q + 4'd1;
            end
          end
          ST_EXECUTE: begin
            // Once the count is reached it holds until the result is valid.
            if (ew_we) begin
              latency_q <= 4'd0;
              stage_q   <= ST_WRITEREG;
            end else if (latency_q < EXEC_LAT_L) begin
              latency_q <= latency_q + 4'd1;
            end
          end
          ST_WRITEREG: begin
            if (latency_q == 4'd0) begin
              latency_q <= 4'd1;
            end else begin
              latency_q <= 4'd0;
              retired_q <= retired_q + 32'd1;
              stage_q   <= stop_req ? ST_STOP : ST_FETCH;
            end
          end
          default: ;  // ST_STOP is terminal until reset
        endcase
      end
    end
  end

  assign mode    = mode_q;
  assign stage   = stage_q;
  assign latency = latency_q;
  assign retired = retired_q;
  assign halted  = (stage_q == ST_STOP);

endmodule
